rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource among N requesters. The resource is typically the 8-input priority-encoded datapath.
- Issues a registered one-hot grant plus a binary grant index.
- Holds the grant while the winner keeps its request asserted.
- Force-releases after a bounded hold time so no requester can starve the others.

---
 rtl/rr_arbiter_pkg.sv | 12 +
 rtl/rr_arbiter_if.sv | 18 +
 rtl/rr_arbiter_prio_pick.sv | 36 +++
 rtl/rr_arbiter.sv | 92 +++++++++
 tb/tb_rr_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared constants for the round-robin arbiter: FSM state encoding and
// default sizing used by the interface, the picker and the top level.
package rr_arb_pkg;

    localparam int N_DEF        = 8;
    localparam int IDW_DEF      = 3;
    localparam int MAX_HOLD_DEF = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int IDW = IDW_DEF
);

    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           timeout;

    modport master (output req, input gnt, gnt_id, gnt_valid, timeout);
    modport slave  (input req, output gnt, gnt_id, gnt_valid, timeout);

endinterface

// File: rtl/rr_arbiter_prio_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping
// from N-1 back to 0.
module rr_prio_pick
    import rr_arb_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int IDW = IDW_DEF
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] winner_o,
    output logic           any_o
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IDW-1:0] offset;

    // Doubling the vector turns the rotate-right into a plain part-select.
    assign req_dbl = {req_i, req_i};
    assign req_rot = req_dbl[ptr_i +: N];

    always_comb begin
        offset = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                offset = IDW'(j);
            end
        end
    end

    // N is a power of two, so the IDW-bit add wraps mod N on its own.
    assign winner_o = offset + ptr_i;
    assign any_o    = |req_i;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold, bounded hold time and a mandatory
// idle cycle between consecutive grants.
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IDW      = IDW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter_if.slave  bus
);

    localparam int             HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [N-1:0]   ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

    logic [0:0]     state_q,   state_d;
    logic [IDW-1:0] ptr_q,     ptr_d;
    logic [HW-1:0]  hcnt_q,    hcnt_d;
    logic [N-1:0]   gnt_q,     gnt_d;
    logic [IDW-1:0] gnt_id_q,  gnt_id_d;
    logic           timeout_q, timeout_d;

    logic [IDW-1:0] winner;
    logic           any_req;

    rr_prio_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d    = ONE_HOT0 << winner;
                    gnt_id_d = winner;
                    hcnt_d   = '0;
                    state_d  = ST_BUSY;
                end
            end
            default: begin
                // A drop on the last allowed cycle is an ordinary release.
                if (!bus.req[gnt_id_q] || (hcnt_q == HOLD_LAST)) begin
                    gnt_d     = '0;
                    ptr_d     = gnt_id_q + IDW'(1);
                    state_d   = ST_IDLE;
                    timeout_d = bus.req[gnt_id_q];
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hcnt_q    <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: behavioural round-robin model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rr_arbiter;

    localparam int N        = 8;
    localparam int IDW      = 3;
    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    rr_arbiter_if #(.N(N), .IDW(IDW)) bus ();

    rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who holds the grant, for how many cycles so far, and where the
    // search starts next time.
    bit m_busy;
    int m_id;
    int m_ptr;
    int m_held;
    bit m_to;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_id   <= 0;
            m_ptr  <= 0;
            m_held <= 0;
            m_to   <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (!m_busy) begin
                if (pick(bus.req, m_ptr) >= 0) begin
                    m_busy <= 1'b1;
                    m_id   <= pick(bus.req, m_ptr);
                    m_held <= 1;
                end
            end else if (!bus.req[m_id]) begin
                m_busy <= 1'b0;
                m_ptr  <= (m_id + 1) % N;
            end else if (m_held == MAX_HOLD) begin
                m_busy <= 1'b0;
                m_ptr  <= (m_id + 1) % N;
                m_to   <= 1'b1;
            end else begin
                m_held <= m_held + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] exp_gnt;
        exp_gnt = m_busy ? (N'(1) << m_id) : '0;
        check("gnt", 32'(bus.gnt), 32'(exp_gnt));
        check("gnt_valid", 32'(bus.gnt_valid), 32'(m_busy));
        check("gnt_id", 32'(bus.gnt_id), 32'(m_id));
        check("timeout", 32'(bus.timeout), 32'(m_to));
        check("onehot", 32'($onehot0(bus.gnt)), 32'd1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int order[$];
    int cnt;

    initial begin
        bus.req = '0;
        rst     = 1'b1;
        repeat (3) step();
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_valid", 32'(bus.gnt_valid), 32'd0);
        check("rst_id", 32'(bus.gnt_id), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        rst = 1'b0;

        // Single requester held three cycles.
        step();
        bus.req = 8'h04;
        step();
        check("single_gnt", 32'(bus.gnt), 32'h04);
        check("single_id", 32'(bus.gnt_id), 32'd2);
        step();
        step();
        check("single_held", 32'(bus.gnt), 32'h04);
        bus.req = '0;
        step();
        check("single_rel", 32'(bus.gnt), 32'd0);
        check("single_id_kept", 32'(bus.gnt_id), 32'd2);
        bus.req = 8'h0C;
        step();
        check("ptr_after_single", 32'(bus.gnt_id), 32'd3);
        bus.req = '0;
        step();
        step();

        // Asynchronous reset in the middle of a grant.
        bus.req = 8'hFF;
        step();
        check("pre_rst_valid", 32'(bus.gnt_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_gnt", 32'(bus.gnt), 32'd0);
        check("async_valid", 32'(bus.gnt_valid), 32'd0);
        check("async_timeout", 32'(bus.timeout), 32'd0);
        step();
        rst = 1'b0;

        // Rotation: each winner drops for one cycle then re-raises.
        for (int i = 0; i < 40 && order.size() < 9; i++) begin
            step();
            if (bus.gnt_valid) begin
                order.push_back(int'(bus.gnt_id));
                bus.req[bus.gnt_id] = 1'b0;
            end else begin
                bus.req = 8'hFF;
            end
        end
        check("rot_count", 32'(order.size()), 32'd9);
        foreach (order[i]) check("rot_order", 32'(order[i]), 32'(i % N));
        bus.req = '0;
        step();
        step();

        // Steer ptr to 6, then wrap past 7 and 0 to reach 1.
        bus.req = 8'h20;
        step();
        check("steer_id", 32'(bus.gnt_id), 32'd5);
        bus.req = '0;
        step();
        bus.req = 8'h22;
        step();
        check("wrap_id", 32'(bus.gnt_id), 32'd1);
        check("wrap_gnt", 32'(bus.gnt), 32'h02);
        bus.req = '0;
        step();
        step();

        // Forced release after MAX_HOLD cycles; other bits ignored while busy.
        bus.req = 8'h01;
        step();
        check("to_first", 32'(bus.gnt_id), 32'd0);
        bus.req = 8'h09;
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!bus.gnt_valid) break;
            cnt++;
        end
        check("to_hold_len", 32'(cnt), 32'd16);
        check("to_pulse", 32'(bus.timeout), 32'd1);
        step();
        check("to_next_id", 32'(bus.gnt_id), 32'd3);
        check("to_pulse_end", 32'(bus.timeout), 32'd0);
        bus.req = '0;
        step();
        step();

        // Request drop coinciding with the last allowed hold cycle.
        bus.req = 8'h01;
        step();
        cnt = 1;
        for (int i = 0; i < 40 && cnt < MAX_HOLD; i++) begin
            step();
            if (bus.gnt_valid) cnt++;
        end
        check("lim_len", 32'(cnt), 32'd16);
        bus.req = '0;
        step();
        check("lim_valid", 32'(bus.gnt_valid), 32'd0);
        check("lim_timeout", 32'(bus.timeout), 32'd0);

        // Randomized traffic with sparse changes so holds reach the limit.
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) bus.req = N'($urandom);
            else if ($urandom_range(0, 29) == 0) bus.req = '0;
        end

        bus.req = '0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
